mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and data (load/store) port.
- Grants at most one access per cycle.
- Routes read data back to the issuing requester after a fixed memory latency.
- Data port has priority by default. A bounded-starvation counter guarantees fetch progress.
- Sits between riscv_core's pc/instr and memory-controller interfaces and a unified RAM.

Parameters:
- MEM_LATENCY, 1, cycles from a granted read to mem_rdata_i valid; legal range 1..4.
- STARVE_LIMIT, 3, consecutive denied fetch cycles after which fetch wins the next tie; 0 means fetch wins every tie; legal range 0..15.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- if_req_i  input  1  fetch read request, held until if_gnt_o
- if_addr_i  input  32  fetch byte address
- if_gnt_o  output  1  fetch request accepted this cycle (combinational)
- if_rvalid_o  output  1  if_rdata_o valid for a fetch read
- if_rdata_o  output  32  fetch read data
- dm_req_i  input  1  data request, held until dm_gnt_o
- dm_we_i  input  4  byte write strobes; 4'b0000 = read
- dm_addr_i  input  32  data byte address
- dm_wdata_i  input  32  store data, lane-aligned
- dm_gnt_o  output  1  data request accepted this cycle (combinational)
- dm_rvalid_o  output  1  dm_rdata_o valid for a data read
- dm_rdata_o  output  32  data read data
- mem_en_o  output  1  memory access strobe
- mem_we_o  output  4  memory byte write strobes
- mem_addr_o  output  32  memory byte address
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, MEM_LATENCY cycles after the read's mem_en_o
- conflict_cnt_o  output  32  count of cycles in which both requesters asserted req

Behaviour:
- Reset: async on rst_n_i low.
  - While low: if_gnt_o, dm_gnt_o, mem_en_o, mem_we_o, if_rvalid_o and dm_rvalid_o are forced to 0.
  - starve_cnt, the tag pipeline and conflict_cnt_o clear to 0.
  - Reads in flight at reset are dropped; no rvalid is produced for them after release.
- Arbitration (combinational, same cycle):
  - Only one requester active: it is granted.
  - Both active: fetch wins iff starve_cnt >= STARVE_LIMIT; otherwise data wins.
  - Exactly one gnt is high whenever any req is high; never both.
- Memory drive:
  - mem_en_o = if_gnt_o | dm_gnt_o.
  - mem_addr_o is the winner's address.
  - mem_we_o = dm_we_i when data is granted, else 0.
  - mem_wdata_o = dm_wdata_i.
  - When idle, mem_addr_o = 0 and mem_we_o = 0.
- starve_cnt (4-bit, saturating at 15):
  - Increments when if_req_i & ~if_gnt_o.
  - Clears when if_gnt_o is high or if_req_i is low.
- Response routing:
  - Each cycle a tag {valid, owner} enters a MEM_LATENCY-deep shift register.
  - valid = granted read (fetch grant, or data grant with dm_we_i == 0). owner = 0 for fetch, 1 for data.
  - At the pipeline output, if_rvalid_o = valid & ~owner and dm_rvalid_o = valid & owner.
  - Exactly one-cycle pulse per read, in grant order. Back-to-back reads are pipelined at one per cycle.
- Writes: no rvalid. The grant cycle is completion.
- Read data: if_rdata_o = dm_rdata_o = mem_rdata_i at all times; meaningful only under the corresponding rvalid.
- conflict_cnt_o: increments each cycle with if_req_i & dm_req_i; wraps 2^32-1 -> 0.
- Requesters must hold addr/we/wdata stable while req & ~gnt. The arbiter does not register requests.
- Deasserting req before gnt is permitted (withdrawal); there is no side effect beyond the starve_cnt clear.

Test Plan:
- Isolated fetch: MEM_LATENCY=1, if_req_i=1, if_addr_i=0x100, mem_rdata_i=0xDEADBEEF on next cycle -> if_gnt_o=1 same cycle; mem_addr_o=0x100, mem_we_o=0; if_rvalid_o=1 next cycle with if_rdata_o=0xDEADBEEF; dm_rvalid_o=0.
- Store: dm_req_i=1, dm_we_i=4'b0011, dm_addr_i=0x2004, dm_wdata_i=0x0000ABCD -> dm_gnt_o=1, mem_we_o=4'b0011, mem_wdata_o=0x0000ABCD; no rvalid in any later cycle.
- Starvation: STARVE_LIMIT=3, both req held continuously -> data granted cycles 0-2; fetch granted cycle 3; data cycle 4; pattern repeats with period 4; conflict_cnt_o=8 after 8 cycles.
- Latency/ordering: MEM_LATENCY=3, fetch read grant at t, data read grant at t+1 -> if_rvalid_o at t+3, dm_rvalid_o at t+4, each exactly one cycle.
- Reset mid-flight: MEM_LATENCY=2, fetch read granted at t, rst_n_i low at t+1 for one cycle -> no if_rvalid_o at t+2; all counters 0 after release.
- Counter wrap: conflict_cnt_o forced via preload/long run to 0xFFFFFFFF, one more conflict cycle -> 0x00000000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the core's instruction-fetch
// port and its data (load/store) port. At most one access is granted per
// cycle. The data port wins ties unless fetch has been denied for
// STARVE_LIMIT consecutive cycles. Read data is routed back to the issuing
// port MEM_LATENCY cycles after the grant.
//
// Parameters
//   MEM_LATENCY    cycles from a granted read to mem_rdata_i valid (1..4)
//   STARVE_LIMIT   denied-fetch cycles after which fetch wins a tie (0..15)
//   CONFLICT_INIT  reset/preload value of conflict_cnt_o (0 in normal use)
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   if_req_i/if_addr_i      fetch read request and byte address
//   if_gnt_o                fetch accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o  fetch read response
//   dm_req_i/dm_we_i        data request, byte strobes (0000 = read)
//   dm_addr_i/dm_wdata_i    data byte address, lane-aligned store data
//   dm_gnt_o                data accepted this cycle (combinational)
//   dm_rvalid_o/dm_rdata_o  data read response
//   mem_en_o/mem_we_o       RAM access strobe and byte write strobes
//   mem_addr_o/mem_wdata_o  RAM byte address and write data
//   mem_rdata_i             RAM read data, MEM_LATENCY cycles after mem_en_o
//   conflict_cnt_o          cycles in which both ports requested (wraps)
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT  = 3,
  parameter logic [31:0] CONFLICT_INIT = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic [3:0]  dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] conflict_cnt_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [3:0]             starve_cnt;
  logic                   fetch_wins;
  logic                   arb_if;
  logic                   arb_dm;
  logic                   rd_vld;
  logic                   rd_own;
  logic [MEM_LATENCY-1:0] vld_p;
  logic [MEM_LATENCY-1:0] own_p;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [31:0] wrap_inc32(input logic [31:0] v);
    return v + 32'd1;
  endfunction

  // Arbitration and RAM drive: purely combinational, same cycle as request.
  always_comb begin
    fetch_wins = (starve_cnt >= STARVE_LIM);
    arb_if     = if_req_i & (~dm_req_i | fetch_wins);
    arb_dm     = dm_req_i & ~arb_if;
    // Grants must read low for the whole time reset is held, even before
    // the first clock edge clears the counters.
    if_gnt_o   = arb_if & rst_n_i;
    dm_gnt_o   = arb_dm & rst_n_i;

    mem_en_o    = if_gnt_o | dm_gnt_o;
    mem_we_o    = dm_gnt_o ? dm_we_i : 4'b0000;
    mem_wdata_o = dm_wdata_i;
    if (if_gnt_o)      mem_addr_o = if_addr_i;
    else if (dm_gnt_o) mem_addr_o = dm_addr_i;
    else               mem_addr_o = 32'h0000_0000;

    // Tag for this cycle: only reads produce a response.
    rd_vld = if_gnt_o | (dm_gnt_o & (dm_we_i == 4'b0000));
    rd_own = dm_gnt_o;
  end

  // Fetch-starvation counter: counts consecutive denied fetch cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= 4'd0;
    end else if (if_req_i & ~if_gnt_o) begin
      starve_cnt <= sat_inc4(starve_cnt);
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      conflict_cnt_o <= CONFLICT_INIT;
    end else if (if_req_i & dm_req_i) begin
      conflict_cnt_o <= wrap_inc32(conflict_cnt_o);
    end
  end

  // Tag pipeline stage 0 .. MEM_LATENCY-1: valid bits are cleared by reset,
  // which drops reads in flight; owner bits only qualify a valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_vld;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    own_p[0] <= rd_own;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      own_p[i] <= own_p[i-1];
    end
  end

  // Pipeline output: steer the response to its owner.
  always_comb begin
    if_rvalid_o = vld_p[MEM_LATENCY-1] & ~own_p[MEM_LATENCY-1];
    dm_rvalid_o = vld_p[MEM_LATENCY-1] & own_p[MEM_LATENCY-1];
    if_rdata_o  = mem_rdata_i;
    dm_rdata_o  = mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Four instances share one stimulus stream:
// MEM_LATENCY 1, 2, 3 and a latency-1 copy whose conflict counter starts at
// 0xFFFFFFFF. A behavioural model (starvation rule, response queue, conflict
// count) is compared every cycle; literal checks pin the model to the
// worked examples.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, dm_req;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_we;

  wire         if_gnt [4];
  wire         dm_gnt [4];
  wire         if_rv  [4];
  wire         dm_rv  [4];
  wire         mem_en [4];
  wire [3:0]   mem_we [4];
  wire [31:0]  mem_addr [4];
  wire [31:0]  mem_wdata [4];
  wire [31:0]  if_rdata [4];
  wire [31:0]  dm_rdata [4];
  wire [31:0]  conf [4];

  int          lat_of [4] = '{1, 2, 3, 1};
  logic [31:0] init_of [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_port_arbiter #(
      .MEM_LATENCY  ((g == 3) ? 1 : g + 1),
      .STARVE_LIMIT (3),
      .CONFLICT_INIT((g == 3) ? 32'hFFFF_FFFF : 32'h0)
    ) u_dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .if_req_i      (if_req),
      .if_addr_i     (if_addr),
      .if_gnt_o      (if_gnt[g]),
      .if_rvalid_o   (if_rv[g]),
      .if_rdata_o    (if_rdata[g]),
      .dm_req_i      (dm_req),
      .dm_we_i       (dm_we),
      .dm_addr_i     (dm_addr),
      .dm_wdata_i    (dm_wdata),
      .dm_gnt_o      (dm_gnt[g]),
      .dm_rvalid_o   (dm_rv[g]),
      .dm_rdata_o    (dm_rdata[g]),
      .mem_en_o      (mem_en[g]),
      .mem_we_o      (mem_we[g]),
      .mem_addr_o    (mem_addr[g]),
      .mem_wdata_o   (mem_wdata[g]),
      .mem_rdata_i   (mem_rdata),
      .conflict_cnt_o(conf[g])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s u%0d: got %h, want %h (t=%0t)", name, g, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_starve = 0;   // consecutive cycles fetch asked and was refused
  logic [31:0] m_conf = 0;     // conflict cycles since reset
  bit   [1:0]  hist[$];        // {is_read, owner_is_data}, newest first

  function automatic bit f_if();
    return rst_n && if_req && (!dm_req || m_starve >= 3);
  endfunction

  function automatic bit f_dm();
    return rst_n && dm_req && !f_if();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_starve = 0;
      m_conf   = 0;
      hist.delete();
    end else begin
      bit gi, gd;
      gi = f_if();
      gd = f_dm();
      hist.push_front({gi | (gd && dm_we == 4'b0000), gd});
      if (hist.size() > 8) void'(hist.pop_back());
      m_starve = (if_req && !gi) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
      if (if_req && dm_req) m_conf = m_conf + 32'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      bit          gi, gd;
      bit   [1:0]  t;
      logic [31:0] ea;
      #2;
      gi = f_if();
      gd = f_dm();
      ea = gi ? if_addr : (gd ? dm_addr : 32'h0);
      for (int g = 0; g < 4; g++) begin
        t = (hist.size() >= lat_of[g]) ? hist[lat_of[g]-1] : 2'b00;
        check("if_gnt",    g, 32'(if_gnt[g]), 32'(gi));
        check("dm_gnt",    g, 32'(dm_gnt[g]), 32'(gd));
        check("mem_en",    g, 32'(mem_en[g]), 32'(gi | gd));
        check("mem_we",    g, 32'(mem_we[g]), 32'(gd ? dm_we : 4'b0000));
        check("mem_addr",  g, mem_addr[g], ea);
        check("mem_wdata", g, mem_wdata[g], dm_wdata);
        check("if_rdata",  g, if_rdata[g], mem_rdata);
        check("dm_rdata",  g, dm_rdata[g], mem_rdata);
        check("if_rvalid", g, 32'(if_rv[g]), 32'(t[1] & ~t[0]));
        check("dm_rvalid", g, 32'(dm_rv[g]), 32'(t[1] & t[0]));
        check("conflict",  g, conf[g], init_of[g] + m_conf);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  logic [7:0] pattern;

  initial begin
    if_req = 0; dm_req = 0; if_addr = 0; dm_addr = 0;
    dm_we = 0; dm_wdata = 0; mem_rdata = 0;
    chk_on = 1'b1;

    // reset state
    tick(); #3;
    check("rst_if_gnt", 0, 32'(if_gnt[0]), 32'd0);
    check("rst_conf",   0, conf[0], 32'd0);
    check("rst_conf_pre", 3, conf[3], 32'hFFFF_FFFF);
    tick(); rst_n = 1'b1;
    tick();

    // isolated fetch
    tick(); if_req = 1; if_addr = 32'h100; #3;
    check("lit_fetch_gnt",  0, 32'(if_gnt[0]), 32'd1);
    check("lit_fetch_addr", 0, mem_addr[0], 32'h100);
    check("lit_fetch_we",   0, 32'(mem_we[0]), 32'd0);
    tick(); if_req = 0; if_addr = 0; mem_rdata = 32'hDEAD_BEEF; #3;
    check("lit_fetch_rv",   0, 32'(if_rv[0]), 32'd1);
    check("lit_fetch_data", 0, if_rdata[0], 32'hDEAD_BEEF);
    check("lit_fetch_dmrv", 0, 32'(dm_rv[0]), 32'd0);
    tick(); mem_rdata = 0;

    // store: granted, no response afterwards (per-cycle compare)
    tick(); dm_req = 1; dm_we = 4'b0011; dm_addr = 32'h2004; dm_wdata = 32'h0000_ABCD; #3;
    check("lit_st_gnt",   0, 32'(dm_gnt[0]), 32'd1);
    check("lit_st_we",    0, 32'(mem_we[0]), 32'h3);
    check("lit_st_wdata", 0, mem_wdata[0], 32'h0000_ABCD);
    tick(); dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    repeat (4) tick();

    // starvation: both held for 8 cycles, fetch wins every 4th
    pattern = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
      end
      #3;
      pattern[i] = if_gnt[0];
      if (i == 1) check("lit_wrap", 3, conf[3], 32'h0);
    end
    tick(); if_req = 0; dm_req = 0; #3;
    check("lit_starve_pattern", 0, 32'(pattern), 32'h88);
    check("lit_conf8",   0, conf[0], 32'd8);
    check("lit_conf8_w", 3, conf[3], 32'd7);

    // latency/ordering with MEM_LATENCY=3 (instance 2)
    tick();
    tick(); if_req = 1; if_addr = 32'h500;                           // t
    tick(); if_req = 0; if_addr = 0; dm_req = 1; dm_addr = 32'h600;  // t+1
    tick(); dm_req = 0; dm_addr = 0; #3;                             // t+2
    check("lit_lat_if_early", 2, 32'(if_rv[2]), 32'd0);
    tick(); #3;                                                      // t+3
    check("lit_lat_if", 2, 32'(if_rv[2]), 32'd1);
    check("lit_lat_dm_early", 2, 32'(dm_rv[2]), 32'd0);
    tick(); #3;                                                      // t+4
    check("lit_lat_if_once", 2, 32'(if_rv[2]), 32'd0);
    check("lit_lat_dm", 2, 32'(dm_rv[2]), 32'd1);
    tick(); #3;                                                      // t+5
    check("lit_lat_dm_once", 2, 32'(dm_rv[2]), 32'd0);

    // reset mid-flight with MEM_LATENCY=2 (instance 1)
    tick(); if_req = 1; if_addr = 32'h700;                           // t
    tick(); if_req = 0; if_addr = 0; rst_n = 0; dm_req = 1; dm_addr = 32'h800; #3;
    check("lit_rst_dm_gnt", 1, 32'(dm_gnt[1]), 32'd0);
    check("lit_rst_mem_en", 1, 32'(mem_en[1]), 32'd0);
    tick(); rst_n = 1; dm_req = 0; dm_addr = 0; #3;                  // t+2
    check("lit_rst_drop", 1, 32'(if_rv[1]), 32'd0);
    check("lit_rst_conf", 0, conf[0], 32'd0);
    tick(); #3;                                                      // t+3
    check("lit_rst_drop3", 2, 32'(if_rv[2]), 32'd0);

    // withdrawal clears starvation
    tick(); if_req = 1; if_addr = 32'h900; dm_req = 1; dm_addr = 32'hA00;  // w0
    tick();                                                                // w1
    tick(); if_req = 0;                                                    // w2
    tick(); if_req = 1;                                                    // w3
    tick();                                                                // w4
    tick(); #3;                                                            // w5
    check("lit_wd_data", 0, 32'(if_gnt[0]), 32'd0);
    tick(); #3;                                                            // w6
    check("lit_wd_fetch", 0, 32'(if_gnt[0]), 32'd1);
    // store contending with fetch: data wins, no response
    tick(); dm_we = 4'b1111; dm_wdata = 32'h1234_5678; #3;                 // w7
    check("lit_st_contend", 0, 32'(dm_gnt[0]), 32'd1);
    tick(); if_req = 0; dm_req = 0; dm_we = 0; dm_wdata = 0;
    repeat (5) tick();
    #3 chk_on = 1'b0;
    tick(); #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
